// File: rtl/pi_controller_pkg.sv
// Shared fixed-point helpers and Q-format sizes for the phase-corrector PI controller.
package pi_controller_pkg;

  localparam int unsigned NB_DATA_DEF  = 16;
  localparam int unsigned NBF_DATA_DEF = 15;
  localparam int unsigned NB_COEF_DEF  = 16;
  localparam int unsigned NBF_COEF_DEF = 15;
  localparam int unsigned NB_GUARD_DEF = 4;

  localparam int unsigned NB_PROD = NB_DATA_DEF + NB_COEF_DEF;
  localparam int unsigned NB_INT  = NB_DATA_DEF + NB_GUARD_DEF;

  // Wide signed working type; every intermediate sum fits without wrap.
  localparam int unsigned NB_FP = 64;
  typedef logic signed [NB_FP-1:0] fp_t;

  typedef enum logic [1:0] {
    INT_UPDATE = 2'd0,
    INT_CLEAR  = 2'd1,
    INT_HOLD   = 2'd2,
    INT_WINDUP = 2'd3
  } int_action_e;

  function automatic fp_t fp_max(input int unsigned n);
    return (fp_t'(1) <<< (n - 1)) - fp_t'(1);
  endfunction

  function automatic fp_t fp_min(input int unsigned n);
    return -(fp_t'(1) <<< (n - 1));
  endfunction

  function automatic fp_t fp_sat(input fp_t x, input int unsigned n);
    if (x > fp_max(n)) return fp_max(n);
    if (x < fp_min(n)) return fp_min(n);
    return x;
  endfunction

  // Floor truncation: arithmetic shift drops LSBs toward minus infinity.
  function automatic fp_t fp_trunc(input fp_t x, input int unsigned nbits);
    return x >>> nbits;
  endfunction

endpackage

// File: rtl/pi_controller_sat_trunc.sv
// Fixed-point requantiser: floor-truncate fractional bits, then saturate to output width.
module pi_controller_sat_trunc
  import pi_controller_pkg::*;
#(
  parameter int unsigned NB_XI  = NB_PROD,
  parameter int unsigned NBF_XI = NBF_DATA_DEF + NBF_COEF_DEF,
  parameter int unsigned NB_XO  = NB_DATA_DEF,
  parameter int unsigned NBF_XO = NBF_DATA_DEF
) (
  input  logic [NB_XI-1:0] i_data,
  output logic [NB_XO-1:0] o_data_c
);

  fp_t x_ext;
  fp_t x_trunc;
  fp_t x_sat;

  always_comb begin
    x_ext    = fp_t'($signed(i_data));
    x_trunc  = fp_trunc(x_ext, NBF_XI - NBF_XO);
    x_sat    = fp_sat(x_trunc, NB_XO);
    o_data_c = NB_XO'(x_sat);
  end

endmodule

// File: rtl/pi_controller.sv
// Positional-form PI controller: two-stage valid pipeline, loadable gains,
// integrator with clear/hold and conditional-integration anti-windup.
module pi_controller
  import pi_controller_pkg::*;
#(
  parameter int unsigned NB_DATA  = NB_DATA_DEF,
  parameter int unsigned NBF_DATA = NBF_DATA_DEF,
  parameter int unsigned NB_COEF  = NB_COEF_DEF,
  parameter int unsigned NBF_COEF = NBF_COEF_DEF,
  parameter int unsigned NB_GUARD = NB_INT - NB_DATA_DEF,
  parameter logic [NB_COEF-1:0] KP_INIT = 16'h0CCC,
  parameter logic [NB_COEF-1:0] KI_INIT = 16'h0666
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_coef_wr,
  input  logic [NB_COEF-1:0] i_kp,
  input  logic [NB_COEF-1:0] i_ki,
  input  logic               i_int_clr,
  input  logic               i_int_hold,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_sat
);

  localparam int unsigned NB_MUL = NB_DATA + NB_COEF;
  localparam int unsigned NB_ACC = NB_DATA + NB_GUARD;

  logic [NB_COEF-1:0] kp_q, ki_q;
  logic               v1_q;
  logic [NB_DATA-1:0] p1_q, q1_q;
  logic [NB_ACC-1:0]  integ_q;

  logic signed [NB_MUL-1:0] x_ext_c, kp_ext_c, ki_ext_c;
  logic signed [NB_MUL-1:0] prod_p_c, prod_q_c;
  logic [NB_DATA-1:0]       p_c, q_c;

  // Stage 1: full-precision products against the currently active gains.
  assign x_ext_c  = NB_MUL'($signed(i_data));
  assign kp_ext_c = NB_MUL'($signed(kp_q));
  assign ki_ext_c = NB_MUL'($signed(ki_q));
  assign prod_p_c = x_ext_c * kp_ext_c;
  assign prod_q_c = x_ext_c * ki_ext_c;

  pi_controller_sat_trunc #(
    .NB_XI (NB_MUL),
    .NBF_XI(NBF_DATA + NBF_COEF),
    .NB_XO (NB_DATA),
    .NBF_XO(NBF_DATA)
  ) u_trunc_p (
    .i_data  (prod_p_c),
    .o_data_c(p_c)
  );

  pi_controller_sat_trunc #(
    .NB_XI (NB_MUL),
    .NBF_XI(NBF_DATA + NBF_COEF),
    .NB_XO (NB_DATA),
    .NBF_XO(NBF_DATA)
  ) u_trunc_q (
    .i_data  (prod_q_c),
    .o_data_c(q_c)
  );

  fp_t               p_w, q_w, integ_w, it_w, s_w, out_w, out_sat_w;
  int_action_e       action_c;
  logic [NB_DATA-1:0] data_nxt_c;
  logic               sat_nxt_c;
  logic [NB_ACC-1:0]  integ_nxt_c;

  // Stage 2: integrator action selection, output saturation, integrator next value.
  always_comb begin
    p_w       = fp_t'($signed(p1_q));
    q_w       = fp_t'($signed(q1_q));
    integ_w   = fp_t'($signed(integ_q));
    it_w      = integ_w + q_w;
    s_w       = p_w + it_w;
    action_c  = INT_UPDATE;
    if (i_int_clr)
      action_c = INT_CLEAR;
    else if (i_int_hold)
      action_c = INT_HOLD;
    else if (((s_w > fp_max(NB_DATA)) && (q_w > fp_t'(0))) ||
             ((s_w < fp_min(NB_DATA)) && (q_w < fp_t'(0))))
      action_c = INT_WINDUP;

    out_w = s_w;
    case (action_c)
      INT_CLEAR: out_w = p_w;
      INT_HOLD:  out_w = p_w + integ_w;
      default:   out_w = s_w;
    endcase
    out_sat_w  = fp_sat(out_w, NB_DATA);
    data_nxt_c = NB_DATA'(out_sat_w);
    sat_nxt_c  = (out_sat_w != out_w);

    // Clear acts every cycle; update only with a stage-2 sample.
    integ_nxt_c = integ_q;
    if (action_c == INT_CLEAR)
      integ_nxt_c = '0;
    else if (v1_q && (action_c == INT_UPDATE))
      integ_nxt_c = NB_ACC'(fp_sat(it_w, NB_ACC));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      kp_q    <= KP_INIT;
      ki_q    <= KI_INIT;
      v1_q    <= 1'b0;
      p1_q    <= '0;
      q1_q    <= '0;
      integ_q <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
    end else begin
      if (i_coef_wr) begin
        kp_q <= i_kp;
        ki_q <= i_ki;
      end
      v1_q <= i_valid;
      if (i_valid) begin
        p1_q <= p_c;
        q1_q <= q_c;
      end
      integ_q <= integ_nxt_c;
      o_valid <= v1_q;
      if (v1_q) begin
        o_data <= data_nxt_c;
        o_sat  <= sat_nxt_c;
      end
    end
  end

endmodule
